hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Parametrised successor to the pipeline's load-use hazard detector. Sits in ID and drives PC write-enable, IF/ID write-enable and the ID/EX bubble.
- Adds configurable multi-cycle load latency, optional branch-resolved-in-ID hazards, register-0 exclusion, operand-use qualification, a halt/freeze input and a saturating stall-cycle performance counter.
- Multi-cycle stalls are held by an internal FSM, because the injected bubbles erase the EX-stage evidence after the first cycle.

Parameters:
- REG_ADDR_W, 5, register address width
- LOAD_STALL, 1, stall cycles for load-use (range 1..7)
- BRANCH_IN_ID, 1, 1 = detect hazards for branches compared in ID; 0 = ignore i_IF_ID_IsBranch
- CNT_W, 16, stall performance counter width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_IF_ID_RegisterRs  in  REG_ADDR_W  ID source 1
- i_IF_ID_RegisterRt  in  REG_ADDR_W  ID source 2
- i_IF_ID_UsesRs  in  1  ID instruction reads Rs
- i_IF_ID_UsesRt  in  1  ID instruction reads Rt
- i_IF_ID_IsBranch  in  1  ID instruction is a branch compared in ID
- i_ID_EX_WriteReg  in  REG_ADDR_W  EX destination register
- i_ID_EX_RegWrite  in  1  EX instruction writes a register
- i_ID_EX_MemRead  in  1  EX instruction is a load
- i_EX_MEM_WriteReg  in  REG_ADDR_W  MEM destination register
- i_EX_MEM_MemRead  in  1  MEM instruction is a load
- i_halt  in  1  freeze the whole front end
- i_clr_count  in  1  synchronous clear of o_stall_cycles
- o_stall  out  1  hazard stall active
- o_pc_write  out  1  PC write enable
- o_if_id_write  out  1  IF/ID write enable
- o_id_ex_flush  out  1  insert bubble into ID/EX
- o_stall_cycles  out  CNT_W  count of hazard-stall cycles

Behaviour:
- Match condition: a source matches a destination only if its Uses bit = 1, the destination != 0, and the addresses are equal.
- Required stall count `need` (combinational, maximum of all active terms):
  - Load-use: i_ID_EX_MemRead and match on Rs or Rt -> LOAD_STALL.
  - If BRANCH_IN_ID = 1 and i_IF_ID_IsBranch = 1:
    - EX ALU producer (i_ID_EX_RegWrite, not MemRead) matches -> 1.
    - EX load matches -> LOAD_STALL+1.
    - MEM load (i_EX_MEM_MemRead) matches -> 1.
  - Otherwise need = 0.
- FSM states: IDLE, HOLD. Internal counter rem, 3 bits.
- IDLE:
  - o_stall = (need != 0), same cycle, zero latency.
  - If need > 1: rem <= need-1, go to HOLD.
  - Else remain in IDLE.
- HOLD:
  - o_stall = 1 and all hazard inputs are ignored.
  - rem decrements each cycle; when rem == 1 the cycle is the last stall, next state IDLE.
  - On return to IDLE, hazards are re-evaluated, so back-to-back hazards chain with no gap and no overlap.
- Total stall for one hazard = exactly `need` consecutive cycles.
- Output equations:
  - o_pc_write = o_if_id_write = ~(o_stall | i_halt)
  - o_id_ex_flush = o_stall & ~i_halt
- i_halt:
  - FSM state and rem are frozen (no transition, no decrement).
  - o_stall keeps its value.
  - Counter does not increment.
  - On release, the stall resumes with the remaining count.
- o_stall_cycles:
  - +1 on every clock edge with o_stall = 1 and i_halt = 0.
  - Saturates at 2^CNT_W-1.
  - i_clr_count has priority over increment and takes effect next edge (value 0).
- Reset (async, while i_rst = 1): state IDLE, rem 0, o_stall_cycles 0, o_stall 0, o_pc_write 1, o_if_id_write 1, o_id_ex_flush 0. Outputs are gated by i_rst, so no stall is visible during reset.
- Reset mid-HOLD aborts the stall immediately. The first edge after release starts in IDLE.
- Simultaneous Rs and Rt hazards of different kinds: the maximum need wins; stalls are not additive.

Test Plan:
- LOAD_STALL=1: EX load to r5, ID uses Rs=r5 -> o_stall=1 same cycle, flush=1, pc_write=0 for exactly 1 cycle; counter=1.
- LOAD_STALL=3: EX load r7, ID Rt=r7; inputs changed to a bubble after cycle 1 -> o_stall high 3 consecutive cycles, then 0; counter=3.
- Register 0 and Uses qualification: EX load to r0 with ID Rs=r0 -> no stall; EX load r4, ID Rt=r4 with UsesRt=0 -> no stall.
- Branch with LOAD_STALL=1:
  - Branch in ID reads r3, EX load r3 -> 2-cycle stall.
  - ALU in EX writes r3 -> 1 cycle.
  - MEM load r3 -> 1 cycle.
  - BRANCH_IN_ID=0 with an ALU producer -> 0 cycles.
- Halt mid-stall, LOAD_STALL=3: assert i_halt in stall cycle 2 for 4 cycles -> o_stall held, flush=0, pc_write=0, counter frozen; after release 2 more stall cycles; counter=3.
- Assert i_rst during HOLD -> outputs go inactive immediately and counter=0. Separately, counter CNT_W=2 saturates at 3, and i_clr_count clears it to 0.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard detector and stall sequencer. It drives the PC and IF/ID write enables and the
// ID/EX bubble, holds multi-cycle stalls internally, and counts stall cycles.
module hazard_stall_controller #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_STALL   = 1,
  parameter bit          BRANCH_IN_ID = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] i_IF_ID_RegisterRt,
  input  logic                  i_IF_ID_UsesRs,
  input  logic                  i_IF_ID_UsesRt,
  input  logic                  i_IF_ID_IsBranch,
  input  logic [REG_ADDR_W-1:0] i_ID_EX_WriteReg,
  input  logic                  i_ID_EX_RegWrite,
  input  logic                  i_ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] i_EX_MEM_WriteReg,
  input  logic                  i_EX_MEM_MemRead,
  input  logic                  i_halt,
  input  logic                  i_clr_count,
  output logic                  o_stall,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_id_ex_flush,
  output logic [CNT_W-1:0]      o_stall_cycles
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  localparam logic [3:0] LoadNeed       = 4'(LOAD_STALL);
  localparam logic [3:0] BranchLoadNeed = 4'(LOAD_STALL + 1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       need;
  logic             stall_raw;
  logic             ex_match, mem_match;
  logic             rs_ex, rt_ex, rs_mem, rt_mem;

  // Register 0 is never a real producer, so it cannot create a hazard.
  always_comb begin
    rs_ex     = i_IF_ID_UsesRs && (i_IF_ID_RegisterRs == i_ID_EX_WriteReg);
    rt_ex     = i_IF_ID_UsesRt && (i_IF_ID_RegisterRt == i_ID_EX_WriteReg);
    rs_mem    = i_IF_ID_UsesRs && (i_IF_ID_RegisterRs == i_EX_MEM_WriteReg);
    rt_mem    = i_IF_ID_UsesRt && (i_IF_ID_RegisterRt == i_EX_MEM_WriteReg);
    ex_match  = (|i_ID_EX_WriteReg) && (rs_ex || rt_ex);
    mem_match = (|i_EX_MEM_WriteReg) && (rs_mem || rt_mem);
  end

  // Maximum over all active hazard terms; stalls never add up.
  always_comb begin
    need = 4'd0;
    if (i_ID_EX_MemRead && ex_match && (need < LoadNeed)) begin
      need = LoadNeed;
    end
    if (BRANCH_IN_ID && i_IF_ID_IsBranch) begin
      if (i_ID_EX_RegWrite && !i_ID_EX_MemRead && ex_match && (need < 4'd1)) begin
        need = 4'd1;
      end
      if (i_ID_EX_MemRead && ex_match && (need < BranchLoadNeed)) begin
        need = BranchLoadNeed;
      end
      if (i_EX_MEM_MemRead && mem_match && (need < 4'd1)) begin
        need = 4'd1;
      end
    end
  end

  // The bubbles erase EX evidence after the first cycle, so HOLD ignores inputs.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    stall_raw = 1'b0;
    case (state_q)
      StIdle: begin
        stall_raw = (need != 4'd0);
        if (!i_halt && (need > 4'd1)) begin
          state_d = StHold;
          rem_d   = 3'(need - 4'd1);
        end
      end
      StHold: begin
        stall_raw = 1'b1;
        if (!i_halt) begin
          if (rem_q <= 3'd1) begin
            state_d = StIdle;
            rem_d   = 3'd0;
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        rem_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr_count) begin
      cnt_d = '0;
    end else if (stall_raw && !i_halt && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      rem_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are masked while reset is held so no stall leaks out of reset.
  always_comb begin
    o_stall        = stall_raw && !i_rst;
    o_pc_write     = i_rst || !(o_stall || i_halt);
    o_if_id_write  = o_pc_write;
    o_id_ex_flush  = o_stall && !i_halt;
    o_stall_cycles = cnt_q;
  end

endmodule
